// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the video/CPU RAM arbiter: FSM encoding, default
// parameter values and the address-width helper.
package ram_arbiter_pkg;

  localparam int DEF_KB   = 128;
  localparam int DEF_VMAX = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  function automatic int addr_width(input int kb);
    return $clog2(kb * 1024);
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Bundle of the video port, CPU port and RAM-side signals around the arbiter.
// The slave modport is the arbiter's view; master is the clients plus RAM.
interface ram_arbiter_if
  import ram_arbiter_pkg::*;
#(
  parameter int AW = addr_width(DEF_KB)
);

  logic          vrd;
  logic [AW-1:0] va;
  logic [7:0]    vq;
  logic          vack;

  logic          crd;
  logic          cwr;
  logic [AW-1:0] ca;
  logic [7:0]    cd;
  logic [7:0]    cq;
  logic          cack;
  logic          cwait;

  logic [AW-1:0] a;
  logic [7:0]    d;
  logic          w;
  logic [7:0]    q;

  modport master (
    output vrd, va, crd, cwr, ca, cd, q,
    input  vq, vack, cq, cack, cwait, a, d, w
  );

  modport slave (
    input  vrd, va, crd, cwr, ca, cd, q,
    output vq, vack, cq, cack, cwait, a, d, w
  );

endinterface

// File: rtl/ram_arbiter.sv
// Arbitrates a video read port and a CPU read/write port onto one synchronous
// RAM. Video wins, but a waiting CPU gets the bus after VMAX video grants.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int KB   = DEF_KB,
  parameter int VMAX = DEF_VMAX
) (
  input logic          clock,
  input logic          reset,
  ram_arbiter_if.slave bus
);

  localparam int AW = addr_width(KB);
  localparam int CW = $clog2(VMAX + 2);

  state_t        state, nstate;
  logic          vpend, cpend;
  logic [AW-1:0] vaddr, caddr;
  logic [7:0]    cdata;
  logic          cwrite;
  logic          owncpu, opwrite;
  logic [CW-1:0] vcnt;

  logic [AW-1:0] areg;
  logic [7:0]    dreg, vqreg, cqreg;
  logic          wreg, vackreg, cackreg;

  logic          vbusy, cbusy, vtake, ctake, vreq, creq, cwins, gntv, gntc;
  logic [AW-1:0] vsela, csela;
  logic [7:0]    cseld;
  logic          cselw;

  // The video slot frees up at the capture edge so back-to-back video reads
  // can stream; the CPU slot stays busy until its ack, matching cwait.
  always_comb begin
    vbusy = vpend || ((state == ACCESS) && !owncpu);
    cbusy = cpend || ((state != IDLE) && owncpu);
    vtake = bus.vrd && !vbusy;
    ctake = (bus.crd || bus.cwr) && !cbusy;
    vreq  = vpend || vtake;
    creq  = cpend || ctake;
    cwins = creq && (!vreq || (cpend && (vcnt == CW'(VMAX))));
    gntv  = (state != ACCESS) && vreq && !cwins;
    gntc  = (state != ACCESS) && cwins;
    vsela = vpend ? vaddr  : bus.va;
    csela = cpend ? caddr  : bus.ca;
    cseld = cpend ? cdata  : bus.cd;
    cselw = cpend ? cwrite : bus.cwr;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:    if (gntv || gntc) nstate = ACCESS;
      ACCESS:  nstate = CAPTURE;
      CAPTURE: nstate = (gntv || gntc) ? ACCESS : IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      vpend   <= 1'b0;
      cpend   <= 1'b0;
      vaddr   <= '0;
      caddr   <= '0;
      cdata   <= '0;
      cwrite  <= 1'b0;
      owncpu  <= 1'b0;
      opwrite <= 1'b0;
      vcnt    <= '0;
      areg    <= '0;
      dreg    <= '0;
      wreg    <= 1'b0;
      vackreg <= 1'b0;
      cackreg <= 1'b0;
      vqreg   <= '0;
      cqreg   <= '0;
    end else begin
      state   <= nstate;
      wreg    <= 1'b0;
      vackreg <= 1'b0;
      cackreg <= 1'b0;

      if (state == CAPTURE) begin
        if (owncpu) begin
          cackreg <= 1'b1;
          if (!opwrite) cqreg <= bus.q;
        end else begin
          vackreg <= 1'b1;
          vqreg   <= bus.q;
        end
      end

      if (vtake) vaddr <= bus.va;
      if (ctake) begin
        caddr  <= bus.ca;
        cdata  <= bus.cd;
        cwrite <= bus.cwr;
      end
      vpend <= vreq && !gntv;
      cpend <= creq && !gntc;

      if (gntv) begin
        areg    <= vsela;
        owncpu  <= 1'b0;
        opwrite <= 1'b0;
      end else if (gntc) begin
        areg    <= csela;
        owncpu  <= 1'b1;
        opwrite <= cselw;
        wreg    <= cselw;
        if (cselw) dreg <= cseld;
      end

      // Fairness counter only runs while the CPU is actually waiting.
      if (gntc || !cpend) vcnt <= '0;
      else if (gntv)      vcnt <= vcnt + 1'b1;
    end
  end

  assign bus.a     = areg;
  assign bus.d     = dreg;
  assign bus.w     = wreg;
  assign bus.vq    = vqreg;
  assign bus.vack  = vackreg;
  assign bus.cq    = cqreg;
  assign bus.cack  = cackreg;
  assign bus.cwait = cbusy;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: table of directed cycles, hand-written corner cases,
// then random traffic against a transaction-level reference model.
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;

  localparam int AW   = 17;
  localparam int VMAX = 3;

  typedef struct {
    bit            rst;
    bit            vrd;
    logic [AW-1:0] va;
    bit            crd;
    bit            cwr;
    logic [AW-1:0] ca;
    logic [7:0]    cd;
  } stim_t;

  typedef struct {
    stim_t         s;
    bit            w;
    bit            vack;
    bit            cack;
    bit            cwait;
    logic [AW-1:0] a;
    logic [7:0]    vq;
    logic [7:0]    cq;
  } vec_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  ram_arbiter_if #(.AW(AW)) bus ();

  ram_arbiter #(.KB(128), .VMAX(VMAX)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  // Synchronous RAM sitting next to the arbiter.
  logic [7:0] mem [0:(1<<AW)-1];
  always @(posedge clock) begin
    if (bus.w) mem[bus.a] <= bus.d;
    bus.q <= mem[bus.a];
  end

  int checks = 0;
  int errors = 0;

  function automatic logic [7:0] initVal(input logic [AW-1:0] addr);
    return 8'(addr[7:0] + addr[15:8] + {7'b0, addr[16]} + 8'h5B);
  endfunction

  function automatic stim_t st(input bit rst, input bit vrd, input logic [AW-1:0] va,
                               input bit crd, input bit cwr, input logic [AW-1:0] ca,
                               input logic [7:0] cd);
    stim_t s;
    s.rst = rst; s.vrd = vrd; s.va = va; s.crd = crd; s.cwr = cwr; s.ca = ca; s.cd = cd;
    return s;
  endfunction

  function automatic vec_t row(input stim_t s, input bit w, input bit vack, input bit cack,
                               input bit cwait, input logic [AW-1:0] a,
                               input logic [7:0] vq, input logic [7:0] cq);
    vec_t v;
    v.s = s; v.w = w; v.vack = vack; v.cack = cack; v.cwait = cwait;
    v.a = a; v.vq = vq; v.cq = cq;
    return v;
  endfunction

  task automatic applyStimulus(input stim_t s);
    reset   = s.rst;
    bus.vrd = s.vrd;
    bus.va  = s.va;
    bus.crd = s.crd;
    bus.cwr = s.cwr;
    bus.ca  = s.ca;
    bus.cd  = s.cd;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference model: tracks pending requests and the one access on the bus
  // as a transaction with a known completion edge.
  bit            mVp, mCp, mCw, mFly, mFlyCpu, mFlyWr;
  logic [AW-1:0] mVa, mCa, mFlyA;
  logic [7:0]    mCd;
  int            mEdge, mAckAt, mVcount;
  bit            eW, eVack, eCack, eCwait;
  logic [AW-1:0] eA;
  logic [7:0]    eVq, eCq, eD;
  logic [7:0]    shadow [logic [AW-1:0]];

  function automatic logic [7:0] readShadow(input logic [AW-1:0] addr);
    return shadow.exists(addr) ? shadow[addr] : initVal(addr);
  endfunction

  task automatic modelStep(input stim_t s);
    bit completing, vBusy, cBusy, cWasWaiting;
    mEdge++;
    eVack = 0; eCack = 0; eW = 0;
    if (s.rst) begin
      mVp = 0; mCp = 0; mFly = 0; mVcount = 0;
      eA = '0; eD = '0; eVq = '0; eCq = '0; eCwait = 0;
      return;
    end
    completing  = mFly && (mAckAt == mEdge);
    vBusy       = mVp || (mFly && !mFlyCpu && !completing);
    cBusy       = mCp || (mFly && mFlyCpu);
    cWasWaiting = mCp;
    if (completing) begin
      if (mFlyCpu) begin
        eCack = 1;
        if (!mFlyWr) eCq = readShadow(mFlyA);
      end else begin
        eVack = 1;
        eVq   = readShadow(mFlyA);
      end
      mFly = 0;
    end
    if (s.vrd && !vBusy) begin mVp = 1; mVa = s.va; end
    if ((s.crd || s.cwr) && !cBusy) begin
      mCp = 1; mCa = s.ca; mCd = s.cd; mCw = s.cwr;
    end
    if (!mFly && (mVp || mCp)) begin
      if (mCp && (!mVp || (cWasWaiting && mVcount >= VMAX))) begin
        mFlyCpu = 1; mFlyA = mCa; mFlyWr = mCw; mCp = 0;
        eA = mCa; eW = mCw;
        if (mCw) begin eD = mCd; shadow[mCa] = mCd; end
        mVcount = 0;
      end else begin
        mFlyCpu = 0; mFlyA = mVa; mFlyWr = 0; mVp = 0;
        eA = mVa;
        if (cWasWaiting) mVcount++;
      end
      mFly = 1; mAckAt = mEdge + 2;
    end
    if (!cWasWaiting) mVcount = 0;
    eCwait = mCp || (mFly && mFlyCpu);
  endtask

  vec_t  tbl [13];
  stim_t idle, s;
  int    cnt, vackCount;
  bit    cackSeen;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = initVal(AW'(i));
    idle = st(0, 0, '0, 0, 0, '0, 8'h00);
    applyStimulus(st(1, 0, '0, 0, 0, '0, 8'h00));

    // Write A5, read it back, then a crd+cwr combo write of 3C and its read.
    tbl[0]  = row(st(1, 0, '0, 0, 0, '0, 8'h00),        0, 0, 0, 0, 17'h00000, 8'h00, 8'h00);
    tbl[1]  = row(st(0, 0, '0, 0, 1, 17'h00100, 8'hA5), 1, 0, 0, 1, 17'h00100, 8'h00, 8'h00);
    tbl[2]  = row(idle,                                 0, 0, 0, 1, 17'h00100, 8'h00, 8'h00);
    tbl[3]  = row(idle,                                 0, 0, 1, 0, 17'h00100, 8'h00, 8'h00);
    tbl[4]  = row(st(0, 0, '0, 1, 0, 17'h00100, 8'h00), 0, 0, 0, 1, 17'h00100, 8'h00, 8'h00);
    tbl[5]  = row(idle,                                 0, 0, 0, 1, 17'h00100, 8'h00, 8'h00);
    tbl[6]  = row(idle,                                 0, 0, 1, 0, 17'h00100, 8'h00, 8'hA5);
    tbl[7]  = row(st(0, 0, '0, 1, 1, 17'h00200, 8'h3C), 1, 0, 0, 1, 17'h00200, 8'h00, 8'hA5);
    tbl[8]  = row(idle,                                 0, 0, 0, 1, 17'h00200, 8'h00, 8'hA5);
    tbl[9]  = row(idle,                                 0, 0, 1, 0, 17'h00200, 8'h00, 8'hA5);
    tbl[10] = row(st(0, 0, '0, 1, 0, 17'h00200, 8'h00), 0, 0, 0, 1, 17'h00200, 8'h00, 8'hA5);
    tbl[11] = row(idle,                                 0, 0, 0, 1, 17'h00200, 8'h00, 8'hA5);
    tbl[12] = row(idle,                                 0, 0, 1, 0, 17'h00200, 8'h00, 8'h3C);

    for (int i = 0; i < 13; i++) begin
      applyStimulus(tbl[i].s);
      tick();
      checkOutput($sformatf("row%0d w", i),     bus.w,     tbl[i].w);
      checkOutput($sformatf("row%0d vack", i),  bus.vack,  tbl[i].vack);
      checkOutput($sformatf("row%0d cack", i),  bus.cack,  tbl[i].cack);
      checkOutput($sformatf("row%0d cwait", i), bus.cwait, tbl[i].cwait);
      checkOutput($sformatf("row%0d a", i),     bus.a,     tbl[i].a);
      checkOutput($sformatf("row%0d vq", i),    bus.vq,    tbl[i].vq);
      checkOutput($sformatf("row%0d cq", i),    bus.cq,    tbl[i].cq);
    end

    // Simultaneous video and CPU reads: video first, CPU two cycles later.
    applyStimulus(st(0, 1, 17'h1FFFF, 1, 0, 17'h00000, 8'h00));
    tick();
    checkOutput("sim k cwait", bus.cwait, 1);
    applyStimulus(idle);
    tick();
    checkOutput("sim k+1 cwait", bus.cwait, 1);
    checkOutput("sim k+1 vack", bus.vack, 0);
    tick();
    checkOutput("sim k+2 vack", bus.vack, 1);
    checkOutput("sim k+2 vq", bus.vq, initVal(17'h1FFFF));
    checkOutput("sim k+2 cwait", bus.cwait, 1);
    tick();
    checkOutput("sim k+3 cwait", bus.cwait, 1);
    checkOutput("sim k+3 cack", bus.cack, 0);
    tick();
    checkOutput("sim k+4 cack", bus.cack, 1);
    checkOutput("sim k+4 cq", bus.cq, initVal(17'h00000));
    checkOutput("sim k+4 cwait", bus.cwait, 0);

    // A second CPU read while stalled is dropped.
    applyStimulus(st(0, 0, '0, 1, 0, 17'h00300, 8'h00));
    tick();
    checkOutput("dup cwait", bus.cwait, 1);
    applyStimulus(st(0, 0, '0, 1, 0, 17'h00301, 8'h00));
    tick();
    applyStimulus(idle);
    cnt = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (bus.cack) cnt++;
    end
    checkOutput("dup cack count", cnt, 1);
    checkOutput("dup cq", bus.cq, initVal(17'h00300));

    // Streaming video with a waiting CPU: the read already in flight plus
    // VMAX further video grants complete before the CPU is served.
    vackCount = 0;
    cackSeen  = 0;
    for (int n = 0; n < 40 && !cackSeen; n++) begin
      s = idle;
      if (n % 2 == 0) begin s.vrd = 1; s.va = AW'(32'h10 + n); end
      if (n == 1) begin s.crd = 1; s.ca = 17'h00020; end
      applyStimulus(s);
      tick();
      if (bus.cack) begin
        cackSeen = 1;
        checkOutput("fair cq", bus.cq, initVal(17'h00020));
      end else if (bus.vack && n >= 1) begin
        vackCount++;
        if (vackCount == 1 + VMAX) checkOutput("fair vcnt cleared", dut.vcnt, 0);
      end
    end
    checkOutput("fair cack seen", cackSeen, 1);
    checkOutput("fair video grants", vackCount, 1 + VMAX);
    applyStimulus(idle);
    repeat (6) tick();
    checkOutput("fair last vq", bus.vq, initVal(17'h00018));

    // Reset during CAPTURE of a video read.
    applyStimulus(st(0, 1, 17'h00040, 0, 0, '0, 8'h00));
    tick();
    applyStimulus(idle);
    tick();
    applyStimulus(st(1, 0, '0, 0, 0, '0, 8'h00));
    tick();
    checkOutput("rstcap vack", bus.vack, 0);
    checkOutput("rstcap vq", bus.vq, 0);
    applyStimulus(idle);
    tick();
    checkOutput("rstcap state", dut.state, IDLE);
    checkOutput("rstcap vack after", bus.vack, 0);

    // Write whose ACCESS cycle meets reset: committed, never acked.
    applyStimulus(st(0, 0, '0, 0, 1, 17'h00500, 8'h77));
    tick();
    applyStimulus(st(1, 0, '0, 0, 0, '0, 8'h00));
    tick();
    checkOutput("rstwr w", bus.w, 0);
    applyStimulus(idle);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.cack) cnt++;
    end
    checkOutput("rstwr no cack", cnt, 0);
    applyStimulus(st(0, 0, '0, 1, 0, 17'h00500, 8'h00));
    tick();
    applyStimulus(idle);
    tick();
    tick();
    checkOutput("rstwr read cack", bus.cack, 1);
    checkOutput("rstwr read cq", bus.cq, 8'h77);

    // Strobes on the reset edge are discarded.
    applyStimulus(st(1, 1, 17'h00600, 1, 0, 17'h00601, 8'h00));
    tick();
    applyStimulus(idle);
    tick();
    checkOutput("rststb cwait", bus.cwait, 0);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.vack || bus.cack) cnt++;
      tick();
    end
    checkOutput("rststb no ack", cnt, 0);

    // Random traffic against the reference model.
    s = st(1, 0, '0, 0, 0, '0, 8'h00);
    applyStimulus(s);
    @(posedge clock);
    mEdge = 0;
    modelStep(s);
    #1;
    for (int i = 0; i < 3000; i++) begin
      s       = idle;
      s.rst   = ($urandom_range(0, 299) == 0);
      s.vrd   = ($urandom_range(0, 9) < 4);
      s.va    = AW'(32'h1000 + $urandom_range(0, 7));
      s.crd   = ($urandom_range(0, 9) < 2);
      s.cwr   = ($urandom_range(0, 9) < 2);
      s.ca    = AW'(32'h1000 + $urandom_range(0, 7));
      s.cd    = 8'($urandom_range(0, 255));
      applyStimulus(s);
      @(posedge clock);
      modelStep(s);
      #1;
      checkOutput("rnd vack",  bus.vack,  eVack);
      checkOutput("rnd cack",  bus.cack,  eCack);
      checkOutput("rnd vq",    bus.vq,    eVq);
      checkOutput("rnd cq",    bus.cq,    eCq);
      checkOutput("rnd cwait", bus.cwait, eCwait);
      checkOutput("rnd w",     bus.w,     eW);
      checkOutput("rnd a",     bus.a,     eA);
      checkOutput("rnd d",     bus.d,     eD);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The block SHALL have parameter KB, default 128, meaning RAM size in KiB; AW = clog2(KB*1024), which is 17 at the default.
REQ-002 The block SHALL have parameter VMAX, default 3, meaning the maximum number of consecutive video grants while a CPU access is pending.
REQ-003 The block SHALL have a single clock; reset is synchronous and active-high.
REQ-004 clock  in  1  system clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 vrd  in  1  video read strobe, one cycle.
REQ-007 va  in  AW  video address, valid with vrd.
REQ-008 vq  out  8  video read data.
REQ-009 vack  out  1  video access complete, one-cycle pulse.
REQ-010 crd  in  1  CPU read strobe, one cycle.
REQ-011 cwr  in  1  CPU write strobe, one cycle.
REQ-012 ca  in  AW  CPU address, valid with crd or cwr.
REQ-013 cd  in  8  CPU write data, valid with cwr.
REQ-014 cq  out  8  CPU read data.
REQ-015 cack  out  1  CPU access complete, one-cycle pulse.
REQ-016 cwait  out  1  CPU stall; high while a CPU access is pending or in flight.
REQ-017 a  out  AW  RAM address (registered).
REQ-018 d  out  8  RAM write data (registered).
REQ-019 w  out  1  RAM write enable (registered).
REQ-020 q  in  8  RAM data; registered by the RAM one edge after a is sampled.

Function
REQ-021 A strobe SHALL latch its address (and cd for writes) into a per-port pending slot; vpend and cpend SHALL be set until the access is granted.
REQ-022 A strobe arriving while that port's slot is already pending or in flight SHALL be ignored, leaving the slot unchanged.
REQ-023 crd and cwr asserted together SHALL be treated as a write.
REQ-024 The FSM SHALL have states IDLE, ACCESS and CAPTURE.
REQ-025 In IDLE, with any pending request or same-cycle strobe, the FSM SHALL grant, register a/d/w and go to ACCESS; otherwise it SHALL stay in IDLE.
REQ-026 ACCESS SHALL last exactly one cycle and then go to CAPTURE; the RAM samples a/d/w at the end of ACCESS.
REQ-027 On leaving ACCESS, w SHALL return to 0, so w is high for exactly one cycle per write.
REQ-028 CAPTURE SHALL last one cycle: at its closing edge the FSM latches q into vq or cq, pulses vack or cack for one cycle and returns to IDLE.
REQ-029 Latency: a strobe sampled at edge k with the FSM in IDLE SHALL give a/w valid after k, RAM sampling at k+1, and data plus ack visible after k+2.
REQ-030 Throughput: a new grant SHALL be allowed at the same edge as the previous ack, i.e. one access per 2 cycles.
REQ-031 Priority: video SHALL win over CPU.
REQ-032 vcnt SHALL count consecutive video grants made while cpend=1; at vcnt=VMAX the next grant SHALL go to the CPU.
REQ-033 vcnt SHALL clear on any CPU grant and whenever cpend=0.
REQ-034 vq and cq SHALL hold their value until the next completed read on their own port; on writes, cq SHALL be left unchanged.
REQ-035 cwait SHALL be high from the cycle after a CPU strobe through the cycle before cack, and low during cack.
REQ-036 The video port SHALL never issue a write; w is driven from the CPU write path only.

Reset
REQ-037 On reset the block SHALL set state=IDLE, vpend=cpend=0, vcnt=0, a=0, d=0, w=0, vack=cack=0, cwait=0, vq=0, cq=0.
REQ-038 Reset mid-access SHALL abort the access without an ack.
REQ-039 A write whose ACCESS cycle coincides with the reset edge SHALL still be committed by the RAM but SHALL not be acked.
REQ-040 Strobes sampled on the same edge as reset SHALL be discarded.

Structure
REQ-041 The FSM state encoding and the default parameter values SHALL live in the shared ep package; everything else SHALL be local to the block.
REQ-042 The block SHALL be implemented without sub-modules; the RAM itself SHALL be instantiated alongside by the parent, not inside this block.

Verification
REQ-043 The bench SHALL cover: reset, then cwr ca=0x00100 cd=0xA5, then crd ca=0x00100 -> w high exactly 1 cycle; cq=0xA5 with cack 2 cycles after the crd edge.
REQ-044 The bench SHALL cover: vrd va=0x1FFFF and crd ca=0x00000 on the same edge -> video granted first (vack at k+2), CPU ack at k+4, cwait high k+1..k+3.
REQ-045 The bench SHALL cover: vrd every 2 cycles continuously with CPU crd pending -> CPU granted after exactly 3 video grants; vcnt then clears.
REQ-046 The bench SHALL cover: a second crd while cwait=1 -> ignored; exactly one cack; cq from the first address.
REQ-047 The bench SHALL cover: reset asserted during CAPTURE of a video read -> no vack, vq=0, FSM in IDLE one cycle after reset deasserts.
REQ-048 The bench SHALL cover: crd and cwr together with cd=0x3C -> treated as a write; a later read returns 0x3C.
